// File: rtl/button_debounce.sv
// Four-channel push-button conditioner: polarity normalize, two-flop sync,
// per-channel stability counter, debounced level plus one-cycle press/release pulses.
module button_debounce #(
  parameter int BTN_ACTIVE   = 1,
  parameter int DEBOUNCE_CYC = 250000,
  parameter int CNT_W        = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0]       norm_s;
  logic [3:0]       sync1_r;
  logic [3:0]       sync2_r;
  logic [CNT_W-1:0] cnt_r [4];

  // Inversion happens ahead of the synchronizer so every stage below sees 1 = pressed.
  assign norm_s = (BTN_ACTIVE != 0) ? btn_raw : ~btn_raw;

  // Two-flop synchronizer for the asynchronous button pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
    end else begin
      sync1_r <= norm_s;
      sync2_r <= sync1_r;
    end
  end

  // Per-channel stability counter; any agreement with the current level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_level   <= 4'b0000;
      btn_press   <= 4'b0000;
      btn_release <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        btn_press[i]   <= 1'b0;
        btn_release[i] <= 1'b0;
        if (sync2_r[i] == btn_level[i]) begin
          cnt_r[i] <= CNT_ZERO;
        end else if (cnt_r[i] == CNT_LAST) begin
          btn_level[i]   <= sync2_r[i];
          btn_press[i]   <= sync2_r[i];
          btn_release[i] <= ~sync2_r[i];
          cnt_r[i]       <= CNT_ZERO;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYC=4, CNT_W=3, both polarities.
module tb_button_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_raw, btn_raw_n;
  logic [3:0] level, press, rel;
  logic [3:0] level_n, press_n, rel_n;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_debounce #(.BTN_ACTIVE(1), .DEBOUNCE_CYC(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_level(level), .btn_press(press), .btn_release(rel));

  button_debounce #(.BTN_ACTIVE(0), .DEBOUNCE_CYC(4), .CNT_W(3)) dut_n (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw_n),
    .btn_level(level_n), .btn_press(press_n), .btn_release(rel_n));

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int npress;
    int press_edge;
    logic [8:0] bounce;

    // Reset then clean press on channel 0
    rst_n = 1'b0; btn_raw = 4'b0000; btn_raw_n = 4'b1111;
    tick(3);
    chk("rst_level", level, 4'b0000);
    chk("rst_press", press, 4'b0000);
    chk("rst_release", rel, 4'b0000);
    chk("rst_level_n", level_n, 4'b0000);
    rst_n = 1'b1; btn_raw = 4'b0001;
    tick(5);
    chk("press_e5_level", level, 4'b0000);
    chk("press_e5_press", press, 4'b0000);
    tick(1);
    chk("press_e6_level", level, 4'b0001);
    chk("press_e6_press", press, 4'b0001);
    chk("press_e6_release", rel, 4'b0000);
    tick(1);
    chk("press_e7_press", press, 4'b0000);
    chk("press_e7_level", level, 4'b0001);

    // Release starts counting; asynchronous reset at cnt 2 clears at once
    btn_raw = 4'b0000;
    tick(4);
    chk("midcnt_level", level, 4'b0001);
    #2 rst_n = 1'b0; btn_raw = 4'b0001;
    #1;
    chk("async_clr_level", level, 4'b0000);
    chk("async_clr_press", press, 4'b0000);
    chk("async_clr_release", rel, 4'b0000);
    tick(1);
    rst_n = 1'b1;
    tick(5);
    chk("post_rst_e5_press", press, 4'b0000);
    chk("post_rst_e5_level", level, 4'b0000);
    tick(1);
    chk("post_rst_e6_press", press, 4'b0001);
    chk("post_rst_e6_level", level, 4'b0001);
    btn_raw = 4'b0000;
    tick(5);
    chk("rel_e5_release", rel, 4'b0000);
    tick(1);
    chk("rel_e6_release", rel, 4'b0001);
    chk("rel_e6_level", level, 4'b0000);
    tick(1);
    chk("rel_e7_release", rel, 4'b0000);

    // Glitch of 3 sampled edges on channel 2: rejected
    btn_raw = 4'b0100;
    tick(3);
    btn_raw = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      chk("glitch3_out", level | press | rel, 4'b0000);
      tick(1);
    end

    // Excursion of 4 sampled edges: accepted, then released 4 cycles later
    btn_raw = 4'b0100;
    tick(4);
    btn_raw = 4'b0000;
    tick(1);
    chk("glitch4_e5_press", press, 4'b0000);
    tick(1);
    chk("glitch4_e6_press", press, 4'b0100);
    chk("glitch4_e6_level", level, 4'b0100);
    tick(3);
    chk("glitch4_e9_release", rel, 4'b0000);
    chk("glitch4_e9_level", level, 4'b0100);
    tick(1);
    chk("glitch4_e10_release", rel, 4'b0100);
    chk("glitch4_e10_level", level, 4'b0000);

    // Bounce on channel 1: single press at edge 11
    tick(3);
    bounce = 9'b111101101;  // bit i is the value sampled at edge i+1
    npress = 0;
    press_edge = 0;
    for (int i = 0; i < 14; i++) begin
      btn_raw = {2'b00, (i < 9) ? bounce[i] : 1'b1, 1'b0};
      tick(1);
      if (press[1]) begin
        npress++;
        press_edge = i + 1;
      end
    end
    chki("bounce_npress", npress, 1);
    chki("bounce_edge", press_edge, 11);
    chk("bounce_level", level, 4'b0010);
    btn_raw = 4'b0000;
    tick(8);
    chk("bounce_rel_level", level, 4'b0000);

    // Simultaneous channels
    btn_raw = 4'b1100;
    tick(5);
    chk("simul_e5_press", press, 4'b0000);
    tick(1);
    chk("simul_e6_press", press, 4'b1100);
    chk("simul_e6_level", level, 4'b1100);
    tick(1);
    chk("simul_e7_press", press, 4'b0000);
    tick(2);
    btn_raw = 4'b0110;
    tick(5);
    chk("swap_e5_pulses", press | rel, 4'b0000);
    tick(1);
    chk("swap_e6_release", rel, 4'b1000);
    chk("swap_e6_press", press, 4'b0010);
    chk("swap_e6_level", level, 4'b0110);
    tick(1);
    chk("swap_e7_pulses", press | rel, 4'b0000);

    // Active-low instance: idle pins stayed released, then press channel 0
    chk("pol_idle_level", level_n, 4'b0000);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1; btn_raw_n = 4'b1110;
    tick(5);
    chk("pol_e5_press", press_n, 4'b0000);
    tick(1);
    chk("pol_e6_press", press_n, 4'b0001);
    chk("pol_e6_level", level_n, 4'b0001);
    chk("pol_e6_release", rel_n, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
# button_debounce

Four-channel button conditioner between the board push-buttons and the snake core's direction controller. Each raw input goes through a two-flop synchronizer and a per-channel stability counter. The block produces clean debounced levels plus one-cycle press and release pulses. The debounced levels feed the left/right/up/down inputs of the direction state logic.

## Interface

- `BTN_ACTIVE`, default 1: raw polarity. 1 means pressed when `btn_raw` is 1; 0 means pressed when `btn_raw` is 0.
- `DEBOUNCE_CYC`, default 250000 (10 ms at 25 MHz): number of consecutive stable cycles required to accept a change. Legal range is 1 to 2^`CNT_W`−1.
- `CNT_W`, default 18: stability counter width.
- One clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `btn_raw`  in  4  asynchronous button pins: [0] left, [1] right, [2] up, [3] down.
- `btn_level`  out  4  debounced state, normalized so 1 means pressed.
- `btn_press`  out  4  one-cycle pulse when `btn_level` bit goes 0→1.
- `btn_release`  out  4  one-cycle pulse when `btn_level` bit goes 1→0.

## Operation

- Normalize the input: `n = BTN_ACTIVE ? btn_raw : ~btn_raw`, applied before the synchronizer.
- Per channel, a two-flop synchronizer `s1 → s2` carries `n` into the clock domain.
- Per-channel state:
  - `level` is 1 bit.
  - `cnt` is `CNT_W` bits, unsigned.
- Each rising edge, per channel:
  - if `s2 == level`: `cnt <= 0`;
  - else if `cnt == DEBOUNCE_CYC-1`: `level <= s2`, `cnt <= 0`, and pulse `btn_press` if `s2` = 1, otherwise pulse `btn_release`;
  - else `cnt <= cnt + 1`.
- A mismatch that disappears for even one cycle resets `cnt` to 0, so counting restarts from scratch.
- `cnt` never exceeds `DEBOUNCE_CYC-1`, so no wrap is possible.
- `btn_press` and `btn_release` are registered. They are asserted in exactly the cycle in which the new `btn_level` value first appears, and deasserted the following cycle. The two are never high together on one channel.
- Channels are fully independent. Simultaneous presses and releases on several channels each produce their own pulses in the same cycle. There is no priority or masking here; priority belongs to the direction controller.
- `DEBOUNCE_CYC` = 1: a change is accepted after a single mismatch cycle, leaving only synchronizer latency.

## Timing

- Reset (`rst_n` = 0), asynchronous, all channels:
  - `s1`, `s2`, `btn_level` = 0 (released);
  - `cnt` = 0;
  - `btn_press`, `btn_release` = 0.
  - Reset asserted mid-count or mid-pulse aborts immediately. After release, a button already held starts a full fresh debounce.
- Latency: count the first rising edge that samples a new stable `btn_raw` value as edge 1. `btn_level` and the pulse update at edge `DEBOUNCE_CYC`+2.
- Glitch rejection:
  - raw excursion sampled for G ≤ `DEBOUNCE_CYC`−1 edges: no output change;
  - G = `DEBOUNCE_CYC`: accepted.
- Minimum spacing between consecutive accepted changes on one channel is `DEBOUNCE_CYC` cycles.
- The block has no handshake. The consumer must sample the pulses every cycle.

## Test plan

All scenarios use `DEBOUNCE_CYC`=4, `CNT_W`=3, `BTN_ACTIVE`=1 unless stated.

- Reset then clean press:
  - stimulus: hold `rst_n`=0 for 3 cycles with `btn_raw`=4'b0000, release reset, raise `btn_raw`[0] to 1 and hold;
  - response: `btn_level`=4'b0001 and `btn_press`=4'b0001 appear at edge 6 and last 1 cycle for the pulse; `btn_release` stays 0.
- Glitch rejection:
  - stimulus: `btn_raw`[2] high for 3 sampled edges, then low;
  - response: `btn_level`, `btn_press` and `btn_release` all stay 0.
  - stimulus: same input but high for 4 edges;
  - response: press pulse at edge 6, then a release pulse 4 cycles after `s2` returns low.
- Bounce:
  - stimulus: `btn_raw`[1] toggles 1,0,1,1,0,1,1,1,1 per cycle;
  - response: exactly one `btn_press`[1] pulse, occurring 4 cycles after the final stable run begins in `s2`.
- Simultaneous channels:
  - stimulus: `btn_raw` 4'b0000 → 4'b1100 in one cycle;
  - response: `btn_press`=4'b1100 in a single cycle, `btn_level`=4'b1100.
  - stimulus: later 4'b1100 → 4'b0110;
  - response: `btn_release`[3] and `btn_press`[1] pulse in the same cycle.
- Reset mid-debounce and polarity:
  - stimulus: with `cnt` at 2, pulse `rst_n` low;
  - response: outputs clear at once; no pulse after release until a full 4-cycle run completes.
  - stimulus: with `BTN_ACTIVE`=0, reset with `btn_raw`=4'b1111, then drive 4'b1110;
  - response: `btn_press`[0] at edge 6.
